// File: rtl/core_pkg.sv
// Shared core types and constants: instruction-memory bundle layout,
// response buffering depth, loader burst limit and the BRAM grant encoding.
package core_pkg;

    localparam int XLEN              = 32;
    localparam int IMEM_RSP_DEPTH    = 2;
    localparam int IMEM_MAX_LD_BURST = 4;

    typedef struct packed {
        logic [XLEN-1:0] pc0;
        logic [XLEN-1:0] pc1;
        logic [XLEN-1:0] instr0;
        logic [XLEN-1:0] instr1;
    } imem_bundle_t;

    typedef enum logic [1:0] {
        GNT_NONE  = 2'd0,
        GNT_FETCH = 2'd1,
        GNT_LOAD  = 2'd2
    } imem_gnt_e;

    function automatic logic [XLEN-1:0] wordAlign(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/imem_ctrl_if.sv
// Fetch, loader and BRAM signals of the instruction-memory controller.
// The slave modport is the controller's view; master is the surrounding system.
interface imem_ctrl_if;
    import core_pkg::*;

    logic            f_req_valid;
    logic            f_req_ready;
    logic [XLEN-1:0] f_req_pc;
    logic            f_flush;
    logic            f_rsp_valid;
    logic            f_rsp_ready;
    logic [XLEN-1:0] f_rsp_pc0;
    logic [XLEN-1:0] f_rsp_pc1;
    logic [XLEN-1:0] f_rsp_instr0;
    logic [XLEN-1:0] f_rsp_instr1;
    logic            ld_valid;
    logic            ld_ready;
    logic [XLEN-1:0] ld_addr;
    logic [XLEN-1:0] ld_wdata;
    logic            mem_ren;
    logic            mem_wen;
    logic [XLEN-1:0] mem_addr0;
    logic [XLEN-1:0] mem_addr1;
    logic [XLEN-1:0] mem_wdata;
    logic [XLEN-1:0] mem_rdata0;
    logic [XLEN-1:0] mem_rdata1;

    modport slave (
        input  f_req_valid, f_req_pc, f_flush, f_rsp_ready,
        input  ld_valid, ld_addr, ld_wdata,
        input  mem_rdata0, mem_rdata1,
        output f_req_ready, f_rsp_valid,
        output f_rsp_pc0, f_rsp_pc1, f_rsp_instr0, f_rsp_instr1,
        output ld_ready,
        output mem_ren, mem_wen, mem_addr0, mem_addr1, mem_wdata
    );

    modport master (
        output f_req_valid, f_req_pc, f_flush, f_rsp_ready,
        output ld_valid, ld_addr, ld_wdata,
        output mem_rdata0, mem_rdata1,
        input  f_req_ready, f_rsp_valid,
        input  f_rsp_pc0, f_rsp_pc1, f_rsp_instr0, f_rsp_instr1,
        input  ld_ready,
        input  mem_ren, mem_wen, mem_addr0, mem_addr1, mem_wdata
    );

endinterface

// File: rtl/imem_rsp_fifo.sv
// Synchronous FIFO of fetch bundles with a clear that beats push and pop.
// Head is read straight from storage so the consumer sees it with no latency.
module imem_rsp_fifo
    import core_pkg::*;
#(
    parameter  int DEPTH = IMEM_RSP_DEPTH,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push_i,
    input  imem_bundle_t pushData_i,
    input  logic         pop_i,
    input  logic         clear_i,
    output imem_bundle_t head_o,
    output logic [CW-1:0] count_o
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] wrPtr_q, wrPtr_d;
    logic [PW-1:0] rdPtr_q, rdPtr_d;
    logic [CW-1:0] count_q, count_d;
    logic          doPush;
    logic          doPop;
    imem_bundle_t  store_q [DEPTH];

    always_comb begin
        doPush  = push_i && (count_q != CW'(DEPTH));
        doPop   = pop_i && (count_q != '0);
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (clear_i) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            count_d = '0;
        end else begin
            if (doPush) wrPtr_d = wrPtr_q + PW'(1);
            if (doPop)  rdPtr_d = rdPtr_q + PW'(1);
            case ({doPush, doPop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: count gates every observable read.
    always_ff @(posedge clk) begin
        if (doPush && !clear_i) store_q[wrPtr_q] <= pushData_i;
    end

    assign head_o  = store_q[rdPtr_q];
    assign count_o = count_q;

endmodule

// File: rtl/imem_ctrl.sv
// Instruction-memory controller: arbitrates the BRAM between fetch and the
// program loader, tracks one read in flight and buffers returned bundles.
module imem_ctrl
    import core_pkg::*;
#(
    parameter int RSP_DEPTH    = IMEM_RSP_DEPTH,
    parameter int MAX_LD_BURST = IMEM_MAX_LD_BURST
) (
    input  logic        clk,
    input  logic        reset,
    imem_ctrl_if.slave  bus
);

    localparam int CW = $clog2(RSP_DEPTH) + 1;
    localparam int BW = $clog2(MAX_LD_BURST + 1);

    logic            inFlight_q, inFlight_d;
    logic [XLEN-1:0] pc0_q, pc0_d;
    logic [XLEN-1:0] pc1_q, pc1_d;
    logic [BW-1:0]   burstCnt_q, burstCnt_d;
    logic [CW-1:0]   fifoCount;
    imem_bundle_t    fifoHead;
    imem_bundle_t    pushBundle;
    imem_gnt_e       gnt;
    logic            canIssue;
    logic            fetchEligible;
    logic            burstFull;
    logic            rspPush;
    logic            rspPop;

    // The loader only yields once it has starved a fetch that could actually issue.
    always_comb begin
        canIssue      = (CW'(inFlight_q) + fifoCount) < CW'(RSP_DEPTH);
        fetchEligible = bus.f_req_valid && canIssue && !bus.f_flush && !reset;
        burstFull     = (burstCnt_q == BW'(MAX_LD_BURST));
        gnt           = GNT_NONE;
        if (bus.ld_valid && !reset && !(burstFull && fetchEligible)) begin
            gnt = GNT_LOAD;
        end else if (fetchEligible) begin
            gnt = GNT_FETCH;
        end
    end

    always_comb begin
        bus.f_req_ready = (gnt == GNT_FETCH);
        bus.ld_ready    = (gnt == GNT_LOAD);
        bus.mem_ren     = 1'b0;
        bus.mem_wen     = 1'b0;
        bus.mem_addr0   = '0;
        bus.mem_addr1   = '0;
        bus.mem_wdata   = '0;
        case (gnt)
            GNT_FETCH: begin
                bus.mem_ren   = 1'b1;
                bus.mem_addr0 = wordAlign(bus.f_req_pc);
                bus.mem_addr1 = wordAlign(bus.f_req_pc) + XLEN'(4);
            end
            GNT_LOAD: begin
                bus.mem_wen   = 1'b1;
                bus.mem_addr0 = wordAlign(bus.ld_addr);
                bus.mem_wdata = bus.ld_wdata;
            end
            default: ;
        endcase
    end

    always_comb begin
        inFlight_d = (gnt == GNT_FETCH);
        pc0_d      = pc0_q;
        pc1_d      = pc1_q;
        if (gnt == GNT_FETCH) begin
            pc0_d = wordAlign(bus.f_req_pc);
            pc1_d = wordAlign(bus.f_req_pc) + XLEN'(4);
        end
        burstCnt_d = burstCnt_q;
        if (gnt == GNT_FETCH || !bus.f_req_valid) begin
            burstCnt_d = '0;
        end else if (gnt == GNT_LOAD && !burstFull) begin
            burstCnt_d = burstCnt_q + BW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            inFlight_q <= 1'b0;
            pc0_q      <= '0;
            pc1_q      <= '0;
            burstCnt_q <= '0;
        end else begin
            inFlight_q <= inFlight_d;
            pc0_q      <= pc0_d;
            pc1_q      <= pc1_d;
            burstCnt_q <= burstCnt_d;
        end
    end

    // A read returning during a flush belongs to the squashed path.
    always_comb begin
        rspPush           = inFlight_q && !bus.f_flush && !reset;
        rspPop            = (fifoCount != '0) && bus.f_rsp_ready;
        pushBundle.pc0    = pc0_q;
        pushBundle.pc1    = pc1_q;
        pushBundle.instr0 = bus.mem_rdata0;
        pushBundle.instr1 = bus.mem_rdata1;
    end

    imem_rsp_fifo #(
        .DEPTH (RSP_DEPTH)
    ) u_rspFifo (
        .clk        (clk),
        .reset      (reset),
        .push_i     (rspPush),
        .pushData_i (pushBundle),
        .pop_i      (rspPop),
        .clear_i    (bus.f_flush),
        .head_o     (fifoHead),
        .count_o    (fifoCount)
    );

    assign bus.f_rsp_valid  = (fifoCount != '0);
    assign bus.f_rsp_pc0    = fifoHead.pc0;
    assign bus.f_rsp_pc1    = fifoHead.pc1;
    assign bus.f_rsp_instr0 = fifoHead.instr0;
    assign bus.f_rsp_instr1 = fifoHead.instr1;

endmodule
